// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter for the single register-file port shared by the core and
// the debug unit, with a bulk-clear sequencer that writes CLEAR_VAL everywhere.
module rf_access_arbiter #(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 3,
    parameter int                 NUM_REGS  = 8,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              clr_req,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              clr_done,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] XFER  = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              last_gnt;
    logic              gnt_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              elig0;
    logic              elig1;
    logic              pick;

    // A requester being acked this cycle still has req high; mask it so the
    // same transaction is not served twice.
    assign elig0 = req0 && !ack0;
    assign elig1 = req1 && !ack1;

    always_comb begin
        if (elig0 && elig1)
            pick = ~last_gnt;
        else
            pick = elig1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last_gnt  <= 1'b1;
            gnt_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            clr_done  <= 1'b0;
        end else begin
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end else if (elig0 || elig1) begin
                        state     <= XFER;
                        gnt_id    <= pick;
                        lat_we    <= pick ? we1    : we0;
                        lat_addr  <= pick ? addr1  : addr0;
                        lat_wdata <= pick ? wdata1 : wdata0;
                    end
                end
                XFER: begin
                    // Combinational read happens before the write lands, so a
                    // write returns the previous contents.
                    rdata    <= rf_rdata;
                    last_gnt <= gnt_id;
                    if (gnt_id)
                        ack1 <= 1'b1;
                    else
                        ack0 <= 1'b1;
                    state <= IDLE;
                end
                CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        cnt      <= '0;
                        state    <= IDLE;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port drive is decoded from state so an async reset drops rf_we at once.
    always_comb begin
        rf_we    = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
        case (state)
            XFER: begin
                rf_we    = lat_we;
                rf_addr  = lat_addr;
                rf_wdata = lat_wdata;
            end
            CLEAR: begin
                rf_we    = 1'b1;
                rf_addr  = cnt;
                rf_wdata = CLEAR_VAL;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Self-checking bench: behavioural register file plus a transaction-level
// reference memory and round-robin model.
module tb_rf_access_arbiter;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, clr_req = 1'b0;
    logic [2:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, clr_done, busy, rf_we;
    logic [7:0] rdata, rf_wdata, rf_rdata;
    logic [2:0] rf_addr;

    logic [7:0] rf_mem [8];
    logic [7:0] ref_mem [8];
    bit         ref_last;
    bit         mem_load = 1'b0;
    int         compared = 0;
    int         mismatched = 0;

    rf_access_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .clr_req(clr_req),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .clr_done(clr_done), .busy(busy),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata)
    );

    always #5 Clk = ~Clk;

    assign rf_rdata = rf_mem[rf_addr];

    always @(posedge Clk) begin
        if (mem_load) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 8'(i);
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_wdata;
        end
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            compared++;
            if (ack0 && ack1) begin
                mismatched++;
                $display("FAIL both_acks: ack0=%0b ack1=%0b required not both 1", ack0, ack1);
            end
            compared++;
            if (rf_we && !busy) begin
                mismatched++;
                $display("FAIL we_idle: rf_we=%0b busy=%0b required rf_we only while busy", rf_we, busy);
            end
        end
    end

    task automatic do_reset();
        Reset = 1'b1; mem_load = 1'b1;
        req0 = 0; req1 = 0; clr_req = 0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0; mem_load = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'(i);
        ref_last = 1'b1;
    endtask

    task automatic xact(input bit id, input bit w, input logic [2:0] a, input logic [7:0] wd,
                        input string nm);
        logic [7:0] exp_d;
        logic [2:0] wa;
        logic [7:0] wdv;
        int cyc, wecnt;
        bit got;
        exp_d = ref_mem[a];
        wa = '0; wdv = '0; cyc = 0; wecnt = 0; got = 0;
        if (!id) begin req0 = 1; we0 = w; addr0 = a; wdata0 = wd; end
        else     begin req1 = 1; we1 = w; addr1 = a; wdata1 = wd; end
        while (!got && cyc < 20) begin
            @(posedge Clk); #1; cyc++;
            if (rf_we) begin wecnt++; wa = rf_addr; wdv = rf_wdata; end
            if (id ? ack1 : ack0) got = 1;
        end
        if (!id) req0 = 0; else req1 = 0;
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL %s timeout: no ack%0d within 20 cycles", nm, id);
        end else begin
            compared++;
            if (cyc !== 2) begin
                mismatched++;
                $display("FAIL %s latency: got %0d cycles required 2", nm, cyc);
            end
            compared++;
            if (rdata !== exp_d) begin
                mismatched++;
                $display("FAIL %s rdata: got %h required %h", nm, rdata, exp_d);
            end
            compared++;
            if (wecnt !== (w ? 1 : 0)) begin
                mismatched++;
                $display("FAIL %s we_cycles: got %0d required %0d", nm, wecnt, w ? 1 : 0);
            end
            if (w) begin
                compared++;
                if (wa !== a || wdv !== wd) begin
                    mismatched++;
                    $display("FAIL %s wport: got addr %0d data %h required addr %0d data %h",
                             nm, wa, wdv, a, wd);
                end
                ref_mem[a] = wd;
            end
            ref_last = id;
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_round_robin(input int n, input string nm);
        bit         cw [2];
        logic [2:0] ca [2];
        logic [7:0] cd [2];
        logic [7:0] e;
        bit expid, id;
        int done_n, cyc;
        done_n = 0; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            cw[i] = 1'($urandom_range(0, 1)); ca[i] = 3'($urandom); cd[i] = 8'($urandom);
        end
        we0 = cw[0]; addr0 = ca[0]; wdata0 = cd[0];
        we1 = cw[1]; addr1 = ca[1]; wdata1 = cd[1];
        req0 = 1; req1 = 1;
        expid = ~ref_last;
        while (done_n < n && cyc < 12 * n) begin
            @(posedge Clk); #1; cyc++;
            if (ack0 || ack1) begin
                id = ack1;
                compared++;
                if (id !== expid) begin
                    mismatched++;
                    $display("FAIL %s order: ack%0d seen, required ack%0d", nm, id, expid);
                end
                e = ref_mem[ca[id]];
                compared++;
                if (rdata !== e) begin
                    mismatched++;
                    $display("FAIL %s rdata: got %h required %h", nm, rdata, e);
                end
                if (cw[id]) ref_mem[ca[id]] = cd[id];
                ref_last = id; expid = ~id; done_n++;
                cw[id] = 1'($urandom_range(0, 1)); ca[id] = 3'($urandom); cd[id] = 8'($urandom);
                if (!id) begin we0 = cw[0]; addr0 = ca[0]; wdata0 = cd[0]; end
                else     begin we1 = cw[1]; addr1 = ca[1]; wdata1 = cd[1]; end
            end
        end
        req0 = 0; req1 = 0;
        compared++;
        if (done_n !== n || cyc !== 2 * n) begin
            mismatched++;
            $display("FAIL %s count: got %0d acks in %0d cycles required %0d in %0d",
                     nm, done_n, cyc, n, 2 * n);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_clear(input bit with_req, input string nm);
        logic [7:0] rd_before;
        int cyc, k, first, done_cyc;
        bit done_seen, ack_seen, fin;
        rd_before = rdata;
        cyc = 0; k = 0; first = -1; done_cyc = -1; done_seen = 0; ack_seen = 0; fin = 0;
        clr_req = 1;
        if (with_req) begin req0 = 1; we0 = 0; addr0 = 3'd7; end
        while (!fin && cyc < 40) begin
            @(posedge Clk); #1; cyc++;
            clr_req = 0;
            if (rf_we) begin
                if (first < 0) first = cyc;
                compared++;
                if (rf_addr !== 3'(k) || rf_wdata !== 8'h00 || cyc !== first + k || done_seen) begin
                    mismatched++;
                    $display("FAIL %s clear_write%0d: got addr %0d data %h cycle %0d required addr %0d data 00 cycle %0d",
                             nm, k, rf_addr, rf_wdata, cyc, k, first + k);
                end
                k++;
            end
            if (clr_done) begin
                done_seen = 1; done_cyc = cyc;
                compared++;
                if (k !== 8 || cyc !== first + 8) begin
                    mismatched++;
                    $display("FAIL %s clr_done: after %0d writes at cycle %0d required 8 writes then cycle %0d",
                             nm, k, cyc, first + 8);
                end
                if (!with_req) begin
                    compared++;
                    if (rdata !== rd_before) begin
                        mismatched++;
                        $display("FAIL %s rdata_kept: got %h required %h", nm, rdata, rd_before);
                    end
                    fin = 1;
                end
            end
            if (ack0) begin
                ack_seen = 1; fin = 1;
                compared++;
                if (!done_seen || rdata !== 8'h00) begin
                    mismatched++;
                    $display("FAIL %s ack_after_clear: done_seen %0b rdata %h required 1 and 00",
                             nm, done_seen, rdata);
                end
            end
        end
        req0 = 0;
        compared++;
        if (!fin || (with_req && !ack_seen)) begin
            mismatched++;
            $display("FAIL %s timeout: done %0b ack %0b required completion", nm, done_seen, ack_seen);
        end
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
        if (with_req) ref_last = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        compared++;
        if ({ack0, ack1, clr_done, busy, rf_we} !== 5'b0 || rdata !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_flags: ack0 %b ack1 %b done %b busy %b we %b rdata %h required all 0",
                     ack0, ack1, clr_done, busy, rf_we, rdata);
        end
        compared++;
        if (rf_addr !== 3'd0 || rf_wdata !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_port: addr %0d wdata %h required 0 and 00", rf_addr, rf_wdata);
        end
    endtask

    task automatic test_reset_mid_xfer();
        bit ack_bad;
        ack_bad = 0;
        req0 = 1; we0 = 1; addr0 = 3'd4; wdata0 = 8'h77;
        @(posedge Clk); #1;
        compared++;
        if (!busy || !rf_we) begin
            mismatched++;
            $display("FAIL rst_xfer_entry: busy %b we %b required 1 1", busy, rf_we);
        end
        #2 Reset = 1'b1;
        #1;
        req0 = 0;
        compared++;
        if (rf_we !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_async: rf_we %b busy %b required 0 0", rf_we, busy);
        end
        repeat (2) begin
            @(posedge Clk); #1;
            if (ack0 || ack1) ack_bad = 1;
        end
        Reset = 1'b0;
        ref_last = 1'b1;
        @(posedge Clk); #1;
        if (ack0 || ack1) ack_bad = 1;
        compared++;
        if (ack_bad || rf_mem[4] !== ref_mem[4]) begin
            mismatched++;
            $display("FAIL rst_abort: ack seen %b reg4 %h required no ack and %h",
                     ack_bad, rf_mem[4], ref_mem[4]);
        end
        test_round_robin(2, "rst_tie");
    endtask

    task automatic test_random(input int iters);
        int r;
        for (int it = 0; it < iters; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0)
                test_clear(1'($urandom_range(0, 1)), "rnd_clear");
            else if (r < 7)
                xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom),
                     8'($urandom), "rnd_xact");
            else
                test_round_robin(2 * $urandom_range(1, 2), "rnd_rr");
        end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (rf_mem[i] !== ref_mem[i]) begin
                mismatched++;
                $display("FAIL rnd_final_mem%0d: got %h required %h", i, rf_mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        xact(0, 0, 3'd5, 8'h00, "read_after_reset");
        xact(0, 1, 3'd2, 8'h3C, "write_pre_value");
        xact(0, 0, 3'd2, 8'h00, "read_back_reg2");
        xact(0, 1, 3'd3, 8'hA5, "write_a5");
        xact(0, 0, 3'd3, 8'h00, "read_back_reg3");
        xact(1, 0, 3'd3, 8'h00, "debug_read");
        test_round_robin(4, "round_robin");
        test_clear(1, "clear_with_req");
        test_clear(0, "clear_alone");
        test_reset_mid_xfer();
        test_random(60);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
